// File: rtl/apb4_splitter_wdt.sv
// APB4 1-to-N splitter with a per-transfer watchdog.
// Decode misses and hung slaves complete upstream with PSLVERR, and error completions are counted.
module apb4_splitter_wdt #(
  parameter int unsigned                          DATA_WIDTH     = 32,
  parameter int unsigned                          ADDR_WIDTH     = 32,
  parameter int unsigned                          N_SLAVES       = 4,
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0]       SLV_BASE       = '0,
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0]       SLV_MASK       = '0,
  parameter int unsigned                          TIMEOUT_CYCLES = 255
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  input  logic [ADDR_WIDTH-1:0]          S_PADDR,
  input  logic                           S_PSEL,
  input  logic                           S_PENABLE,
  input  logic                           S_PWRITE,
  input  logic [DATA_WIDTH-1:0]          S_PWDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_PSTRB,
  input  logic [2:0]                     S_PPROT,
  output logic                           S_PREADY,
  output logic [DATA_WIDTH-1:0]          S_PRDATA,
  output logic                           S_PSLVERR,
  output logic [N_SLAVES-1:0]            M_PSEL,
  output logic [ADDR_WIDTH-1:0]          M_PADDR,
  output logic                           M_PENABLE,
  output logic                           M_PWRITE,
  output logic [DATA_WIDTH-1:0]          M_PWDATA,
  output logic [DATA_WIDTH/8-1:0]        M_PSTRB,
  output logic [2:0]                     M_PPROT,
  input  logic [N_SLAVES-1:0]            M_PREADY,
  input  logic [N_SLAVES*DATA_WIDTH-1:0] M_PRDATA,
  input  logic [N_SLAVES-1:0]            M_PSLVERR,
  output logic [7:0]                     err_cnt
);

  localparam int unsigned IdxW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StMiss, StAbort} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic [15:0]       cnt_q;
  logic [7:0]        err_cnt_q;

  logic                  hit;
  logic [IdxW-1:0]       hit_idx;
  logic                  setup;
  logic                  sel_ready;
  logic                  timeout;
  logic [N_SLAVES-1:0]   psel;
  logic                  penable;
  logic                  pready;
  logic                  pslverr;
  logic [DATA_WIDTH-1:0] prdata;

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((S_PADDR & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
      end
    end
  end

  assign setup     = S_PSEL & ~S_PENABLE;
  assign sel_ready = M_PREADY[idx_q];
  assign timeout   = (cnt_q == 16'(TIMEOUT_CYCLES)) & ~sel_ready;

  always_comb begin
    psel    = '0;
    penable = 1'b0;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    unique case (state_q)
      StIdle: begin
        if (setup && hit) begin
          for (int i = 0; i < N_SLAVES; i++) psel[i] = (hit_idx == IdxW'(i));
        end
      end
      StAccess: begin
        if (S_PSEL) begin
          if (timeout) begin
            pready  = 1'b1;
            pslverr = 1'b1;
          end else begin
            for (int i = 0; i < N_SLAVES; i++) psel[i] = (idx_q == IdxW'(i));
            penable = S_PENABLE;
            pready  = sel_ready;
            pslverr = sel_ready & M_PSLVERR[idx_q];
            if (sel_ready && !S_PWRITE) prdata = M_PRDATA[idx_q*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      StMiss: begin
        if (S_PSEL && S_PENABLE) begin
          pready  = 1'b1;
          pslverr = 1'b1;
        end
      end
      StAbort: ;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      if (pready && pslverr && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (setup) begin
            if (hit) begin
              idx_q   <= hit_idx;
              state_q <= StAccess;
            end else begin
              state_q <= StMiss;
            end
          end
        end
        StAccess: begin
          if (!S_PSEL || sel_ready) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q == 16'(TIMEOUT_CYCLES)) begin
            state_q <= StAbort;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StMiss: begin
          if (!S_PSEL || S_PENABLE) state_q <= StIdle;
        end
        StAbort: state_q <= StIdle;
      endcase
    end
  end

  // Reset gates the outputs combinationally so selects drop the moment PRESET rises.
  assign M_PSEL    = PRESET ? '0 : psel;
  assign M_PENABLE = ~PRESET & penable;
  assign M_PADDR   = PRESET ? '0 : S_PADDR;
  assign M_PWRITE  = ~PRESET & S_PWRITE;
  assign M_PWDATA  = PRESET ? '0 : S_PWDATA;
  assign M_PSTRB   = PRESET ? '0 : S_PSTRB;
  assign M_PPROT   = PRESET ? '0 : S_PPROT;
  assign S_PREADY  = ~PRESET & pready;
  assign S_PSLVERR = ~PRESET & pslverr;
  assign S_PRDATA  = PRESET ? '0 : prdata;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_apb4_splitter_wdt.sv
// Directed bench for apb4_splitter_wdt: vector table of single transfers plus
// hand-written timeout, late-ready, saturation and mid-transfer reset sequences.
module tb_apb4_splitter_wdt;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [31:0] S_PADDR;
  logic        S_PSEL, S_PENABLE, S_PWRITE;
  logic [31:0] S_PWDATA;
  logic [3:0]  S_PSTRB;
  logic [2:0]  S_PPROT;
  logic        S_PREADY, S_PSLVERR;
  logic [31:0] S_PRDATA;
  logic [3:0]  M_PSEL;
  logic [31:0] M_PADDR, M_PWDATA;
  logic        M_PENABLE, M_PWRITE;
  logic [3:0]  M_PSTRB;
  logic [2:0]  M_PPROT;
  logic [3:0]  M_PREADY, M_PSLVERR;
  logic [127:0] M_PRDATA;
  logic [7:0]  err_cnt;

  // Slave 3 overlaps slave 0 in the 0x4000 page.
  apb4_splitter_wdt #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .N_SLAVES       (4),
    .SLV_BASE       ({32'h0000_4000, 32'h0000_2000, 32'h0000_1000, 32'h0000_4000}),
    .SLV_MASK       ({32'h0000_FF00, 32'h0000_F000, 32'h0000_F000, 32'h0000_F000}),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .S_PADDR   (S_PADDR),
    .S_PSEL    (S_PSEL),
    .S_PENABLE (S_PENABLE),
    .S_PWRITE  (S_PWRITE),
    .S_PWDATA  (S_PWDATA),
    .S_PSTRB   (S_PSTRB),
    .S_PPROT   (S_PPROT),
    .S_PREADY  (S_PREADY),
    .S_PRDATA  (S_PRDATA),
    .S_PSLVERR (S_PSLVERR),
    .M_PSEL    (M_PSEL),
    .M_PADDR   (M_PADDR),
    .M_PENABLE (M_PENABLE),
    .M_PWRITE  (M_PWRITE),
    .M_PWDATA  (M_PWDATA),
    .M_PSTRB   (M_PSTRB),
    .M_PPROT   (M_PPROT),
    .M_PREADY  (M_PREADY),
    .M_PRDATA  (M_PRDATA),
    .M_PSLVERR (M_PSLVERR),
    .err_cnt   (err_cnt)
  );

  always #5 PCLK = ~PCLK;

  assign M_PRDATA = {32'hD0D0_0003, 32'hD0D0_0002, 32'hD0D0_0001, 32'hD0D0_0000};

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  slv_err;
    logic [3:0]  exp_sel;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[8];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          exp_err_cnt = 0;
  logic [3:0]  sel_setup, sel_acc;
  logic        rdy, err;
  logic [31:0] rdata, paddr, pwdata;
  int          n_cyc;
  logic        got;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                         output logic [3:0] o_sel_setup, output logic [3:0] o_sel_acc,
                         output logic o_rdy, output logic [31:0] o_rdata, output logic o_err,
                         output logic [31:0] o_paddr, output logic [31:0] o_pwdata);
    @(posedge PCLK); #1;
    S_PADDR = addr; S_PWRITE = wr; S_PWDATA = wdata; S_PSEL = 1'b1; S_PENABLE = 1'b0;
    @(negedge PCLK);
    o_sel_setup = M_PSEL;
    @(posedge PCLK); #1;
    S_PENABLE = 1'b1;
    @(negedge PCLK);
    o_sel_acc = M_PSEL; o_rdy = S_PREADY; o_rdata = S_PRDATA; o_err = S_PSLVERR;
    o_paddr = M_PADDR; o_pwdata = M_PWDATA;
    @(posedge PCLK); #1;
    S_PSEL = 1'b0; S_PENABLE = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h2004, 1'b1, 32'h55,        4'b0000, 4'b0100, 32'h0,         1'b0};
    vecs[1] = '{32'h2008, 1'b0, 32'h0,         4'b0000, 4'b0100, 32'hD0D0_0002, 1'b0};
    vecs[2] = '{32'h1000, 1'b0, 32'h0,         4'b0000, 4'b0010, 32'hD0D0_0001, 1'b0};
    vecs[3] = '{32'h4010, 1'b0, 32'h0,         4'b0000, 4'b0001, 32'hD0D0_0000, 1'b0};
    vecs[4] = '{32'h9000, 1'b0, 32'h0,         4'b0000, 4'b0000, 32'h0,         1'b1};
    vecs[5] = '{32'h4F00, 1'b0, 32'h0,         4'b0000, 4'b0001, 32'hD0D0_0000, 1'b0};
    vecs[6] = '{32'h1004, 1'b0, 32'h0,         4'b0010, 4'b0010, 32'hD0D0_0001, 1'b1};
    vecs[7] = '{32'h3000, 1'b1, 32'hCAFE_F00D, 4'b0000, 4'b0000, 32'h0,         1'b1};

    PRESET = 1'b1;
    S_PADDR = 32'h2004; S_PSEL = 1'b1; S_PENABLE = 1'b0; S_PWRITE = 1'b1;
    S_PWDATA = 32'h1234_5678; S_PSTRB = 4'hF; S_PPROT = 3'b010;
    M_PREADY = 4'b1111; M_PSLVERR = 4'b0000;
    #2;
    check("reset_psel",    32'(M_PSEL),    32'h0);
    check("reset_paddr",   M_PADDR,        32'h0);
    check("reset_pready",  32'(S_PREADY),  32'h0);
    check("reset_err_cnt", 32'(err_cnt),   32'h0);
    S_PSEL = 1'b0;
    @(posedge PCLK); @(posedge PCLK); #1;
    PRESET = 1'b0;

    for (int v = 0; v < 8; v++) begin
      M_PSLVERR = vecs[v].slv_err;
      do_xfer(vecs[v].addr, vecs[v].wr, vecs[v].wdata,
              sel_setup, sel_acc, rdy, rdata, err, paddr, pwdata);
      if (vecs[v].exp_err) exp_err_cnt = sat_inc(exp_err_cnt);
      check($sformatf("v%0d_sel_setup", v), 32'(sel_setup), 32'(vecs[v].exp_sel));
      check($sformatf("v%0d_sel_acc", v),   32'(sel_acc),   32'(vecs[v].exp_sel));
      check($sformatf("v%0d_pready", v),    32'(rdy),       32'h1);
      check($sformatf("v%0d_prdata", v),    rdata,          vecs[v].exp_rdata);
      check($sformatf("v%0d_pslverr", v),   32'(err),       32'(vecs[v].exp_err));
      check($sformatf("v%0d_m_paddr", v),   paddr,          vecs[v].addr);
      check($sformatf("v%0d_m_pwdata", v),  pwdata,         vecs[v].wdata);
      check($sformatf("v%0d_err_cnt", v),   32'(err_cnt),   32'(exp_err_cnt));
    end
    M_PSLVERR = 4'b0000;

    // Hung slave 1: abort expected on the 9th ACCESS cycle.
    M_PREADY = 4'b1101;
    @(posedge PCLK); #1;
    S_PADDR = 32'h1010; S_PWRITE = 1'b0; S_PSEL = 1'b1; S_PENABLE = 1'b0;
    @(posedge PCLK); #1;
    S_PENABLE = 1'b1;
    n_cyc = 0; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge PCLK);
      n_cyc++;
      if (S_PREADY) got = 1'b1;
      else check($sformatf("to_wait%0d_psel", n_cyc), 32'(M_PSEL), 32'h2);
    end
    check("to_cycles",    n_cyc,            9);
    check("to_pslverr",   32'(S_PSLVERR),   32'h1);
    check("to_prdata",    S_PRDATA,         32'h0);
    check("to_psel",      32'(M_PSEL),      32'h0);
    check("to_penable",   32'(M_PENABLE),   32'h0);
    @(posedge PCLK); #1;
    S_PSEL = 1'b0; S_PENABLE = 1'b0;
    exp_err_cnt = sat_inc(exp_err_cnt);
    @(negedge PCLK);
    check("abort_psel",   32'(M_PSEL),      32'h0);
    check("abort_pready", 32'(S_PREADY),    32'h0);
    check("abort_err_cnt", 32'(err_cnt),    32'(exp_err_cnt));

    // Slave 1 becomes ready exactly on the timeout cycle: real ready wins.
    @(posedge PCLK); #1;
    S_PADDR = 32'h1020; S_PSEL = 1'b1; S_PENABLE = 1'b0;
    @(posedge PCLK); #1;
    S_PENABLE = 1'b1;
    repeat (8) @(posedge PCLK);
    #1 M_PREADY = 4'b1111;
    @(negedge PCLK);
    check("late_pready",  32'(S_PREADY),    32'h1);
    check("late_pslverr", 32'(S_PSLVERR),   32'h0);
    check("late_prdata",  S_PRDATA,         32'hD0D0_0001);
    check("late_psel",    32'(M_PSEL),      32'h2);
    @(posedge PCLK); #1;
    S_PSEL = 1'b0; S_PENABLE = 1'b0;
    check("late_err_cnt", 32'(err_cnt),     32'(exp_err_cnt));

    // 300 decode misses saturate the error counter.
    for (int n = 0; n < 300; n++) begin
      do_xfer(32'h9000, 1'b0, 32'h0, sel_setup, sel_acc, rdy, rdata, err, paddr, pwdata);
      exp_err_cnt = sat_inc(exp_err_cnt);
      if (n == 100) check("sat_mid_err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
    end
    check("sat_err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
    check("sat_value",   32'(err_cnt), 32'd255);

    // Reset asserted mid-ACCESS against a stalled slave 2.
    M_PREADY = 4'b1011;
    @(posedge PCLK); #1;
    S_PADDR = 32'h2000; S_PSEL = 1'b1; S_PENABLE = 1'b0;
    @(posedge PCLK); #1;
    S_PENABLE = 1'b1;
    @(negedge PCLK);
    check("prerst_psel", 32'(M_PSEL), 32'h4);
    #1 PRESET = 1'b1;
    #1;
    check("rst_psel",    32'(M_PSEL),    32'h0);
    check("rst_pready",  32'(S_PREADY),  32'h0);
    check("rst_penable", 32'(M_PENABLE), 32'h0);
    check("rst_err_cnt", 32'(err_cnt),   32'h0);
    exp_err_cnt = 0;
    S_PSEL = 1'b0; S_PENABLE = 1'b0; M_PREADY = 4'b1111;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    do_xfer(32'h2000, 1'b0, 32'h0, sel_setup, sel_acc, rdy, rdata, err, paddr, pwdata);
    check("post_rst_sel",     32'(sel_acc), 32'h4);
    check("post_rst_pready",  32'(rdy),     32'h1);
    check("post_rst_prdata",  rdata,        32'hD0D0_0002);
    check("post_rst_pslverr", 32'(err),     32'h0);
    check("post_rst_err_cnt", 32'(err_cnt), 32'(exp_err_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
